// File: rtl/iccm_ecc_pkg.sv
// rtl/iccm_ecc_pkg.sv - shared SECDED(39,32) types, widths and check-bit generator for ICCM ECC.
package iccm_ecc_pkg;

   localparam int HALF_W = 39;
   localparam int DATA_W = 32;
   localparam int CHK_W  = 7;
   localparam int WORD_W = 2 * HALF_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      WRITE = 2'd2
   } corr_state_e;

   // Hamming position of data bit idx: non-power-of-two slots 3..38.
   function automatic logic [CHK_W-2:0] data_pos(input int idx);
      int k;
      data_pos = '0;
      k = 0;
      for (int pos = 3; pos < HALF_W; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (k == idx) data_pos = 6'(pos);
            k++;
         end
      end
   endfunction

   function automatic logic [CHK_W-2:0] ham_gen(input logic [DATA_W-1:0] d);
      ham_gen = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (d[i]) ham_gen = ham_gen ^ data_pos(i);
      end
   endfunction

   // ecc[6] makes the whole 39-bit half even parity.
   function automatic logic [CHK_W-1:0] ecc_gen(input logic [DATA_W-1:0] d);
      logic [CHK_W-2:0] h;
      h = ham_gen(d);
      ecc_gen = {^{h, d}, h};
   endfunction

endpackage

// File: rtl/iccm_ecc_dec.sv
// rtl/iccm_ecc_dec.sv - SECDED(39,32) decode and correct of one {ecc[6:0], data[31:0]} half.
module iccm_ecc_dec
   import iccm_ecc_pkg::*;
(
   input  logic [HALF_W-1:0] din,
   output logic [DATA_W-1:0] data_corr,
   output logic              sb,
   output logic              db
);

   logic [DATA_W-1:0] data;
   logic [CHK_W-2:0]  syn_ham;
   logic              parity;

   assign data    = din[DATA_W-1:0];
   assign syn_ham = ham_gen(data) ^ din[HALF_W-2:DATA_W];
   assign parity  = ^din;

   // Syndrome is {parity, syn_ham}; a lone ecc[6] flip is still a single-bit error.
   assign sb = parity;
   assign db = (|syn_ham) & ~parity;

   always_comb begin
      data_corr = data;
      for (int i = 0; i < DATA_W; i++) begin
         data_corr[i] = data[i] ^ (parity && (syn_ham == data_pos(i)));
      end
   end

endmodule

// File: rtl/iccm_ecc_corr_ctl.sv
// rtl/iccm_ecc_corr_ctl.sv - ICCM read ECC detection and single-bit correction write-back.
// Write-back FSM is built only with ICCM_ECC_CORR_WRITEBACK_EN defined; otherwise detection pulses only.
module iccm_ecc_corr_ctl
   import iccm_ecc_pkg::*;
#(
   parameter int ICCM_BITS     = 16,
   parameter int CORR_WAIT_MAX = 7
)
(
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 iccm_rd_valid,
   input  logic [ICCM_BITS-1:1] iccm_rd_addr,
   input  logic [WORD_W-1:0]    iccm_rd_data_ecc,
   input  logic                 dec_tlu_core_ecc_disable,
   input  logic                 dma_iccm_req,
   output logic                 iccm_wren,
   output logic [ICCM_BITS-1:1] iccm_rw_addr,
   output logic [2:0]           iccm_wr_size,
   output logic [WORD_W-1:0]    iccm_wr_data,
   output logic                 iccm_buf_correct_ecc,
   output logic                 iccm_correction_state,
   output logic                 iccm_sb_err,
   output logic                 iccm_db_err,
   output logic [7:0]           corr_count
);

   logic [DATA_W-1:0] corr_lo, corr_hi;
   logic              sb_lo, sb_hi, db_lo, db_hi;
   logic              chk_en, any_db, new_sb;

   iccm_ecc_dec u_dec_lo (
      .din       (iccm_rd_data_ecc[HALF_W-1:0]),
      .data_corr (corr_lo),
      .sb        (sb_lo),
      .db        (db_lo)
   );

   iccm_ecc_dec u_dec_hi (
      .din       (iccm_rd_data_ecc[WORD_W-1:HALF_W]),
      .data_corr (corr_hi),
      .sb        (sb_hi),
      .db        (db_hi)
   );

   assign chk_en = iccm_rd_valid & ~dec_tlu_core_ecc_disable;
   assign any_db = db_lo | db_hi;
   assign new_sb = chk_en & (sb_lo | sb_hi) & ~any_db;

   assign iccm_wr_size = 3'b011;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         iccm_sb_err <= 1'b0;
         iccm_db_err <= 1'b0;
      end else begin
         iccm_sb_err <= new_sb;
         iccm_db_err <= chk_en & any_db;
      end
   end

`ifdef ICCM_ECC_CORR_WRITEBACK_EN
   corr_state_e       state, state_nxt;
   logic [7:0]        wait_cnt, wait_cnt_nxt;
   logic              cap_en;
   logic [WORD_W-1:0] wr_data_nxt;

   assign wr_data_nxt = {ecc_gen(corr_hi), corr_hi, ecc_gen(corr_lo), corr_lo};

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      cap_en       = 1'b0;
      unique case (state)
         IDLE: begin
            if (new_sb) begin
               state_nxt    = PEND;
               wait_cnt_nxt = '0;
               cap_en       = 1'b1;
            end
         end
         PEND: begin
            // DMA keeps priority until the wait budget runs out.
            if (!dma_iccm_req || (wait_cnt == 8'(CORR_WAIT_MAX))) state_nxt = WRITE;
            else wait_cnt_nxt = wait_cnt + 8'd1;
         end
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         iccm_rw_addr <= '0;
         iccm_wr_data <= '0;
         corr_count   <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (cap_en) begin
            iccm_rw_addr <= iccm_rd_addr;
            iccm_wr_data <= wr_data_nxt;
         end
         if ((state == WRITE) && (corr_count != 8'hff)) corr_count <= corr_count + 8'd1;
      end
   end

   assign iccm_wren             = (state == WRITE);
   assign iccm_buf_correct_ecc  = (state == WRITE);
   assign iccm_correction_state = (state != IDLE);
`else
   logic unused_wb_inputs;
   assign unused_wb_inputs = ^{iccm_rd_addr, dma_iccm_req, corr_lo, corr_hi};

   assign iccm_wren             = 1'b0;
   assign iccm_buf_correct_ecc  = 1'b0;
   assign iccm_correction_state = 1'b0;
   assign iccm_rw_addr          = '0;
   assign iccm_wr_data          = '0;
   assign corr_count            = '0;
`endif

endmodule

// File: tb/tb_iccm_ecc_corr_ctl.sv
// tb/tb_iccm_ecc_corr_ctl.sv - directed self-checking bench for iccm_ecc_corr_ctl.
module tb_iccm_ecc_corr_ctl;

`ifdef ICCM_ECC_CORR_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   // Hand-encoded clean halves: data 0x1 -> ecc 0x43, data 0x8000_0000 -> ecc 0x26.
   localparam logic [77:0] GOOD = {7'h26, 32'h8000_0000, 7'h43, 32'h0000_0001};

   logic        clk;
   logic        rst_l;
   logic        iccm_rd_valid;
   logic [15:1] iccm_rd_addr;
   logic [77:0] iccm_rd_data_ecc;
   logic        dec_tlu_core_ecc_disable;
   logic        dma_iccm_req;
   logic        iccm_wren;
   logic [15:1] iccm_rw_addr;
   logic [2:0]  iccm_wr_size;
   logic [77:0] iccm_wr_data;
   logic        iccm_buf_correct_ecc;
   logic        iccm_correction_state;
   logic        iccm_sb_err;
   logic        iccm_db_err;
   logic [7:0]  corr_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [77:0] w;
   logic        seen;

   iccm_ecc_corr_ctl #(.ICCM_BITS(16), .CORR_WAIT_MAX(7)) dut (
      .clk                      (clk),
      .rst_l                    (rst_l),
      .iccm_rd_valid            (iccm_rd_valid),
      .iccm_rd_addr             (iccm_rd_addr),
      .iccm_rd_data_ecc         (iccm_rd_data_ecc),
      .dec_tlu_core_ecc_disable (dec_tlu_core_ecc_disable),
      .dma_iccm_req             (dma_iccm_req),
      .iccm_wren                (iccm_wren),
      .iccm_rw_addr             (iccm_rw_addr),
      .iccm_wr_size             (iccm_wr_size),
      .iccm_wr_data             (iccm_wr_data),
      .iccm_buf_correct_ecc     (iccm_buf_correct_ecc),
      .iccm_correction_state    (iccm_correction_state),
      .iccm_sb_err              (iccm_sb_err),
      .iccm_db_err              (iccm_db_err),
      .corr_count               (corr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [77:0] wb(input logic [77:0] v);
      return WB ? v : 78'd0;
   endfunction

   initial begin
      rst_l = 1'b1;
      iccm_rd_valid = 1'b0;
      iccm_rd_addr = '0;
      iccm_rd_data_ecc = '0;
      dec_tlu_core_ecc_disable = 1'b0;
      dma_iccm_req = 1'b0;
      #2 rst_l = 1'b0;
      #1;
      check("rst_wren", iccm_wren, 0);
      check("rst_wr_size", iccm_wr_size, 3'b011);
      check("rst_sb", iccm_sb_err, 0);
      check("rst_db", iccm_db_err, 0);
      check("rst_state", iccm_correction_state, 0);
      check("rst_bufc", iccm_buf_correct_ecc, 0);
      check("rst_count", corr_count, 0);
      check("rst_addr", iccm_rw_addr, 0);
      check("rst_data", iccm_wr_data, 0);
      tick(); tick();
      rst_l = 1'b1;
      tick();

      // Clean words: all-zero and the hand-encoded pair
      iccm_rd_valid = 1'b1; iccm_rd_data_ecc = '0; iccm_rd_addr = 15'h10;
      tick();
      check("clean0_sb", iccm_sb_err, 0);
      check("clean0_db", iccm_db_err, 0);
      iccm_rd_data_ecc = GOOD;
      tick();
      check("clean_sb", iccm_sb_err, 0);
      check("clean_db", iccm_db_err, 0);
      check("clean_state", iccm_correction_state, 0);
      iccm_rd_valid = 1'b0;

      // Flip low data bit 5 at 0x40, DMA idle
      w = GOOD; w[5] = ~w[5];
      iccm_rd_data_ecc = w; iccm_rd_addr = 15'h40; iccm_rd_valid = 1'b1;
      tick();
      check("sb1_pulse", iccm_sb_err, 1);
      check("sb1_db", iccm_db_err, 0);
      check("sb1_pend", iccm_correction_state, wb(1));
      check("sb1_pend_wren", iccm_wren, 0);
      check("sb1_addr", iccm_rw_addr, wb(15'h40));
      iccm_rd_valid = 1'b0;
      tick();
      check("sb1_pulse_end", iccm_sb_err, 0);
      check("sb1_wren", iccm_wren, wb(1));
      check("sb1_bufc", iccm_buf_correct_ecc, wb(1));
      check("sb1_wr_addr", iccm_rw_addr, wb(15'h40));
      check("sb1_wr_data", iccm_wr_data, wb(GOOD));
      tick();
      check("sb1_wren_end", iccm_wren, 0);
      check("sb1_idle", iccm_correction_state, 0);
      check("sb1_count", corr_count, wb(1));

      // Upper bits 3 and 9 flipped plus a low single: double wins
      w = GOOD; w[42] = ~w[42]; w[48] = ~w[48]; w[0] = ~w[0];
      iccm_rd_data_ecc = w; iccm_rd_addr = 15'h60; iccm_rd_valid = 1'b1;
      tick();
      iccm_rd_valid = 1'b0;
      check("db_pulse", iccm_db_err, 1);
      check("db_no_sb", iccm_sb_err, 0);
      check("db_no_pend", iccm_correction_state, 0);
      tick();
      check("db_pulse_end", iccm_db_err, 0);
      check("db_no_wren", iccm_wren, 0);
      check("db_still_idle", iccm_correction_state, 0);

      // ECC disabled: no pulse, no capture
      dec_tlu_core_ecc_disable = 1'b1;
      w = GOOD; w[7] = ~w[7];
      iccm_rd_data_ecc = w; iccm_rd_valid = 1'b1;
      tick();
      check("dis_sb", iccm_sb_err, 0);
      check("dis_state", iccm_correction_state, 0);
      dec_tlu_core_ecc_disable = 1'b0;
      iccm_rd_valid = 1'b0;

      // ecc[6] flip under DMA pressure; second error and disable during PEND
      dma_iccm_req = 1'b1;
      w = GOOD; w[38] = ~w[38];
      iccm_rd_data_ecc = w; iccm_rd_addr = 15'h100; iccm_rd_valid = 1'b1;
      tick();
      check("p_sb", iccm_sb_err, 1);
      check("p_pend", iccm_correction_state, wb(1));
      w = GOOD; w[39] = ~w[39];
      iccm_rd_data_ecc = w; iccm_rd_addr = 15'h80;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) check("p_second_sb", iccm_sb_err, 1);
         iccm_rd_valid = 1'b0;
         if (k == 3) dec_tlu_core_ecc_disable = 1'b1;
         check($sformatf("p_wait_wren_%0d", k), iccm_wren, 0);
         check($sformatf("p_wait_addr_%0d", k), iccm_rw_addr, wb(15'h100));
      end
      tick();
      check("p_wren_8th", iccm_wren, wb(1));
      check("p_wr_addr", iccm_rw_addr, wb(15'h100));
      check("p_wr_data", iccm_wr_data, wb(GOOD));
      dec_tlu_core_ecc_disable = 1'b0;
      dma_iccm_req = 1'b0;
      tick();
      check("p_idle", iccm_correction_state, 0);
      check("p_count", corr_count, wb(2));

      // Reset in the middle of PEND discards the correction
      dma_iccm_req = 1'b1;
      w = GOOD; w[70] = ~w[70];
      iccm_rd_data_ecc = w; iccm_rd_addr = 15'h200; iccm_rd_valid = 1'b1;
      tick();
      iccm_rd_valid = 1'b0;
      check("r_pend", iccm_correction_state, wb(1));
      tick(); tick();
      #2 rst_l = 1'b0;
      #1;
      check("r_state", iccm_correction_state, 0);
      check("r_wren", iccm_wren, 0);
      check("r_addr", iccm_rw_addr, 0);
      check("r_data", iccm_wr_data, 0);
      check("r_count", corr_count, 0);
      tick();
      rst_l = 1'b1;
      dma_iccm_req = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen = seen | iccm_wren | iccm_correction_state;
      end
      check("r_no_write_after", seen, 0);

      // 256 corrections saturate the counter
      for (int i = 0; i < 256; i++) begin
         w = GOOD; w[0] = ~w[0];
         iccm_rd_data_ecc = w; iccm_rd_addr = 15'(i); iccm_rd_valid = 1'b1;
         tick();
         iccm_rd_valid = 1'b0;
         tick(); tick();
         if (i == 254) check("sat_255th", corr_count, wb(255));
      end
      check("sat_256th", corr_count, wb(255));
      check("sat_last_addr", iccm_rw_addr, wb(15'hff));
      check("sat_wren_idle", iccm_wren, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
